// File: rtl/wash_ctrl_param.sv
// Washing machine controller with parameterised phase durations.
// Two-process FSM: state/timer register plus combinational next-state and output decode.
module wash_ctrl_param #(
   parameter int TW      = 8,
   parameter int FILL_T  = 4,
   parameter int WASH_T  = 8,
   parameter int DRAIN_T = 3,
   parameter int RINSE_T = 5,
   parameter int SPIN_T  = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          power,
   input  logic [2:0]    program_selection,
   input  logic          start,
   input  logic          pause,
   input  logic          doorclosed,
   input  logic          soap,
   output logic          valve_in_cold,
   output logic          valve_in_hot,
   output logic          valve_out,
   output logic [1:0]    motor,
   output logic [TW-1:0] timer_display,
   output logic          program_done,
   output logic          soap_warning,
   output logic          soap_in,
   output logic          lockDoor
);

   typedef enum logic [3:0] {
      IDLE,
      FILL,
      SOAP_WAIT,
      WASH,
      DRAIN,
      RINSE,
      SPIN,
      PAUSED,
      DONE
   } state_t;

   localparam logic [TW-1:0] FILL_V  = TW'(FILL_T - 1);
   localparam logic [TW-1:0] WASH_V  = TW'(WASH_T - 1);
   localparam logic [TW-1:0] DRAIN_V = TW'(DRAIN_T - 1);
   localparam logic [TW-1:0] RINSE_V = TW'(RINSE_T - 1);
   localparam logic [TW-1:0] SPIN_V  = TW'(SPIN_T - 1);

   state_t        state, state_n;
   state_t        saved, saved_n;
   logic [TW-1:0] timer, timer_n;
   logic          prog_hot, prog_hot_n;
   logic          first, first_n;

   // Start value of the phase timer for a given state; 0 for untimed states.
   function automatic logic [TW-1:0] phase_len(input state_t s);
      case (s)
         FILL:    return FILL_V;
         WASH:    return WASH_V;
         DRAIN:   return DRAIN_V;
         RINSE:   return RINSE_V;
         SPIN:    return SPIN_V;
         default: return '0;
      endcase
   endfunction

   // State register; reset clears the program, timer and pause context.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         saved    <= IDLE;
         timer    <= '0;
         prog_hot <= 1'b0;
         first    <= 1'b0;
      end else begin
         state    <= state_n;
         saved    <= saved_n;
         timer    <= timer_n;
         prog_hot <= prog_hot_n;
         first    <= first_n;
      end
   end

   // Next-state logic: power loss beats pause, pause beats expiry, expiry beats start.
   always_comb begin
      state_n    = state;
      saved_n    = saved;
      timer_n    = timer;
      prog_hot_n = prog_hot;
      first_n    = 1'b0;
      if (!power) begin
         state_n    = IDLE;
         saved_n    = IDLE;
         timer_n    = '0;
         prog_hot_n = 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start && doorclosed && !program_selection[2]) begin
                  prog_hot_n = program_selection[0];
                  case (program_selection[1:0])
                     2'b10:   state_n = RINSE;
                     2'b11:   state_n = SPIN;
                     default: state_n = FILL;
                  endcase
                  timer_n = phase_len(state_n);
               end
            end
            SOAP_WAIT: begin
               if (soap) begin
                  state_n = WASH;
                  timer_n = WASH_V;
                  first_n = 1'b1;
               end
            end
            PAUSED: begin
               if (pause) begin
                  state_n = saved;
               end
            end
            default: begin
               if (pause) begin
                  state_n = PAUSED;
                  saved_n = state;
               end else if (timer == '0) begin
                  case (state)
                     FILL:    state_n = soap ? WASH : SOAP_WAIT;
                     WASH:    state_n = DRAIN;
                     DRAIN:   state_n = RINSE;
                     RINSE:   state_n = SPIN;
                     default: state_n = DONE;
                  endcase
                  first_n = (state == FILL) && soap;
                  timer_n = phase_len(state_n);
               end else begin
                  timer_n = timer - TW'(1);
               end
            end
         endcase
      end
   end

   // Moore output decode from the current state.
   always_comb begin
      valve_in_cold = 1'b0;
      valve_in_hot  = 1'b0;
      valve_out     = 1'b0;
      motor         = 2'b00;
      soap_warning  = 1'b0;
      program_done  = 1'b0;
      lockDoor      = 1'b1;
      case (state)
         IDLE: lockDoor = 1'b0;
         DONE: begin
            lockDoor     = 1'b0;
            program_done = 1'b1;
         end
         FILL: begin
            valve_in_cold = !prog_hot;
            valve_in_hot  = prog_hot;
         end
         SOAP_WAIT: soap_warning = 1'b1;
         WASH:  motor = 2'b01;
         DRAIN: valve_out = 1'b1;
         RINSE: begin
            valve_in_cold = 1'b1;
            motor         = 2'b01;
         end
         SPIN: begin
            valve_out = 1'b1;
            motor     = 2'b10;
         end
         default: ;
      endcase
      timer_display = timer;
      soap_in       = first;
   end

endmodule
